// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parameterised up/down event counter with modulus MAX_COUNT.
// Features: synchronous clear and load, wrap/saturate boundary mode,
// a registered terminal-count pulse (tc) and a sticky boundary flag (ovf).
// Optional build macro COUNTER_PRESCALE_EN adds parameter PRESCALE and a divider
// so that only every PRESCALE-th enabled cycle steps the counter.
// Parameter limits: WIDTH >= 2, 1 <= MAX_COUNT <= 2**WIDTH-1, RESET_VAL <= MAX_COUNT.
`timescale 1ns/1ps

module counter_updown_mod #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 64'd0
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int unsigned     PRESCALE  = 4
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] result,
  output logic             tc,
  output logic             ovf
);

  // Boundary and reset values narrowed to the counter width once, so every
  // compare below stays WIDTH bits wide.
  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             tc_reg;
  logic             ovf_reg;
  logic             ovf_next;
  logic             boundary;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  // A divider of at least one bit keeps PRESCALE=1 legal: its only state is 0,
  // so every enabled cycle is a tick, matching the undivided build.
  localparam int unsigned      DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             tick;

  assign tick = (div_reg == DIV_LAST);

  // Divider: restarts on clr/load, otherwise advances once per enabled cycle.
  always_comb begin
    div_next = div_reg;
    if (clr || load) begin
      div_next = '0;
    end else if (ena) begin
      div_next = tick ? '0 : (div_reg + DIV_ONE);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  assign step = ena & tick;
`else
  assign step = ena;
`endif

  // Next count: clr beats load beats a step. The boundary is detected by
  // comparing before stepping, so the add/subtract never wraps naturally.
  always_comb begin
    result_next = result_reg;
    boundary    = 1'b0;
    if (clr) begin
      result_next = '0;
    end else if (load) begin
      result_next = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      if (up) begin
        if (result_reg == MAX_V) begin
          boundary    = 1'b1;
          result_next = sat ? MAX_V : '0;
        end else begin
          result_next = result_reg + ONE_V;
        end
      end else begin
        if (result_reg == '0) begin
          boundary    = 1'b1;
          result_next = sat ? '0 : MAX_V;
        end else begin
          result_next = result_reg - ONE_V;
        end
      end
    end
  end

  // Sticky flag: a boundary event in the same cycle overrides clr_ovf.
  always_comb begin
    ovf_next = boundary | (ovf_reg & ~clr_ovf);
  end

  // Output registers; tc mirrors the boundary event so it lines up with the
  // post-event count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_reg <= RST_V;
      tc_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      result_reg <= result_next;
      tc_reg     <= boundary;
      ovf_reg    <= ovf_next;
    end
  end

  assign result = result_reg;
  assign tc     = tc_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: directed bench for counter_updown_mod.
// Instance 0: WIDTH=8, MAX_COUNT=255, RESET_VAL=0 (full-range counting, async reset).
// Instance 1: WIDTH=8, MAX_COUNT=9,   RESET_VAL=3 (modulus, saturate, priority, ovf).
// Instance 2: WIDTH=8, MAX_COUNT=1,   RESET_VAL=0 (degenerate toggle counter).
`timescale 1ns/1ps

module tb_counter_updown_mod;

  logic       clk;
  logic       rst_n;
  logic       ena      [3];
  logic       up       [3];
  logic       sat      [3];
  logic       clr      [3];
  logic       load     [3];
  logic [7:0] load_val [3];
  logic       clr_ovf  [3];
  logic [7:0] result   [3];
  logic       tc       [3];
  logic       ovf      [3];

  int total;
  int passed;

  typedef struct {
    int         dut;
    bit         ena;
    bit         up;
    bit         sat;
    bit         clr;
    bit         load;
    logic [7:0] lv;
    bit         clr_ovf;
    logic [7:0] exp_result;
    bit         exp_tc;
    bit         exp_ovf;
    string      name;
  } vec_t;

  vec_t vecs[$];

  counter_updown_mod #(.WIDTH(8), .MAX_COUNT(64'd255), .RESET_VAL(64'd0)) u_w8 (
    .clk(clk), .reset_n(rst_n), .ena(ena[0]), .up(up[0]), .sat(sat[0]),
    .clr(clr[0]), .load(load[0]), .load_val(load_val[0]), .clr_ovf(clr_ovf[0]),
    .result(result[0]), .tc(tc[0]), .ovf(ovf[0])
  );

  counter_updown_mod #(.WIDTH(8), .MAX_COUNT(64'd9), .RESET_VAL(64'd3)) u_m9 (
    .clk(clk), .reset_n(rst_n), .ena(ena[1]), .up(up[1]), .sat(sat[1]),
    .clr(clr[1]), .load(load[1]), .load_val(load_val[1]), .clr_ovf(clr_ovf[1]),
    .result(result[1]), .tc(tc[1]), .ovf(ovf[1])
  );

  counter_updown_mod #(.WIDTH(8), .MAX_COUNT(64'd1), .RESET_VAL(64'd0)) u_m1 (
    .clk(clk), .reset_n(rst_n), .ena(ena[2]), .up(up[2]), .sat(sat[2]),
    .clr(clr[2]), .load(load[2]), .load_val(load_val[2]), .clr_ovf(clr_ovf[2]),
    .result(result[2]), .tc(tc[2]), .ovf(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dut(input string name, input int d, input int er, input int et, input int eo);
    check({name, ".result"}, int'(result[d]), er);
    check({name, ".tc"},     int'(tc[d]),     et);
    check({name, ".ovf"},    int'(ovf[d]),    eo);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      ena[d] = 1'b0; up[d] = 1'b0; sat[d] = 1'b0; clr[d] = 1'b0;
      load[d] = 1'b0; load_val[d] = 8'd0; clr_ovf[d] = 1'b0;
    end
  endtask

  function automatic void add(input int d, input bit e, input bit u, input bit s,
                              input bit c, input bit l, input logic [7:0] lv,
                              input bit co, input logic [7:0] er, input bit et,
                              input bit eo, input string nm);
    vec_t v;
    v.dut = d; v.ena = e; v.up = u; v.sat = s; v.clr = c; v.load = l;
    v.lv = lv; v.clr_ovf = co; v.exp_result = er; v.exp_tc = et;
    v.exp_ovf = eo; v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    total  = 0;
    passed = 0;

    //   dut ena up sat clr load lv  covf  res tc ovf  name
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0, 1'b0, "m9_clr");
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd9, 1'b1, 1'b1, "m9_down_wrap");
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd8, 1'b0, 1'b1, "m9_down");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 8'd0, 1'b0, 1'b1, "m9_load0");
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 8'd9, 1'b1, 1'b1, "m9_set_wins");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 8'd9, 1'b0, 1'b0, "m9_clr_ovf");
    add(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 1'b0, 8'd9, 1'b0, 1'b0, "m9_load_clamp");
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd9, 1'b1, 1'b1, "m9_sat_up1");
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd9, 1'b1, 1'b1, "m9_sat_up2");
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd9, 1'b1, 1'b1, "m9_sat_up3");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0, 8'd5, 1'b0, 1'b1, "m9_load5");
    add(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd7,   1'b0, 8'd0, 1'b0, 1'b1, "m9_clr_prio");
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7,   1'b0, 8'd7, 1'b0, 1'b1, "m9_load_prio");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd7, 1'b0, 1'b1, "m9_hold");
    add(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd6, 1'b0, 1'b1, "m9_down_sat_mid");
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 8'd0, 1'b0, 1'b0, "m9_clr_and_clr_ovf");
    add(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b1, 1'b1, "m9_down_sat_floor");
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd1, 1'b0, 1'b1, "m9_up_after_sat");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,   1'b0, 8'd9, 1'b0, 1'b1, "m9_load9");
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b1, 1'b1, "m9_up_wrap");
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd1, 1'b0, 1'b0, "m1_up1");
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b1, 1'b1, "m1_up_wrap");
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd1, 1'b0, 1'b1, "m1_up2");
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0, 1'b1, "m1_down");
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd1, 1'b1, 1'b1, "m1_down_wrap");
    add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0, 8'd1, 1'b0, 1'b1, "m1_load_clamp");
    add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 8'd1, 1'b0, 1'b0, "m1_clr_ovf");
    add(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd1, 1'b1, 1'b1, "m1_sat_top");

    // Reset state of all instances.
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    check_dut("reset_w8", 0, 0, 0, 0);
    check_dut("reset_m9", 1, 3, 0, 0);
    check_dut("reset_m1", 2, 0, 0, 0);

    // Full-range count: 260 enabled edges, wrap 255 -> 0 on edge 256.
    @(negedge clk);
    rst_n  = 1'b1;
    ena[0] = 1'b1;
    up[0]  = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk);
      #1;
      check_dut($sformatf("w8_count%0d", k), 0, k % 256, (k == 256) ? 1 : 0, (k >= 256) ? 1 : 0);
    end
    idle_all();

    // Table of single-cycle vectors.
    foreach (vecs[i]) begin
      idle_all();
      ena[vecs[i].dut]      = vecs[i].ena;
      up[vecs[i].dut]       = vecs[i].up;
      sat[vecs[i].dut]      = vecs[i].sat;
      clr[vecs[i].dut]      = vecs[i].clr;
      load[vecs[i].dut]     = vecs[i].load;
      load_val[vecs[i].dut] = vecs[i].lv;
      clr_ovf[vecs[i].dut]  = vecs[i].clr_ovf;
      @(posedge clk);
      #1;
      check_dut(vecs[i].name, vecs[i].dut, int'(vecs[i].exp_result),
                int'(vecs[i].exp_tc), int'(vecs[i].exp_ovf));
    end
    idle_all();

    // Asynchronous reset in the middle of a count at 0x42.
    load[0]     = 1'b1;
    load_val[0] = 8'h40;
    @(posedge clk);
    #1;
    check_dut("w8_load40", 0, 8'h40, 0, 1);
    load[0] = 1'b0;
    ena[0]  = 1'b1;
    up[0]   = 1'b1;
    @(posedge clk);
    #1;
    check_dut("w8_count41", 0, 8'h41, 0, 1);
    @(posedge clk);
    #1;
    check_dut("w8_count42", 0, 8'h42, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_dut("w8_async_reset", 0, 0, 0, 0);
    check_dut("m9_async_reset", 1, 3, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_dut("w8_resume1", 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_dut("w8_resume2", 0, 2, 0, 0);
    idle_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
